branch_controller: RTL
======================

Name: branch_controller

Overview:
- Control-transfer stage directly upstream of the program counter.
- Decodes the control-flow field of the instruction in execute and drives the PC's LoadValue/LoadEnable/Offset/OffsetEnable inputs.
- Holds the condition-flags register, a return-address stack for CALL/RET, and a RUN/FLUSH/HALTED state machine.
- The state machine squashes the wrong-path slot after a taken transfer and freezes the PC on HALT or stack error.

Parameters:
- STACK_DEPTH, 8, number of return-address entries (power of 2, ≥2)
- ADDR_WIDTH, 16, PC/address width (signed, matches PC)
- OFFSET_WIDTH, 9, relative-branch offset width (signed, matches PC)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- InstrValid  in  1  instruction in execute slot is valid
- Opcode  in  4  control-flow opcode of that instruction
- InstrPC  in  ADDR_WIDTH  PC of that instruction (signed)
- Target  in  ADDR_WIDTH  absolute target for JMP/CALL (signed)
- Immediate  in  OFFSET_WIDTH  relative offset for BR/Bcc (signed)
- FlagsIn  in  4  {V,C,N,Z} from ALU
- FlagsWrite  in  1  update flags register
- LoadValue  out  ADDR_WIDTH  to PC LoadValue
- LoadEnable  out  1  to PC LoadEnable
- Offset  out  OFFSET_WIDTH  to PC Offset
- OffsetEnable  out  1  to PC OffsetEnable
- Flush  out  1  current execute slot is squashed
- Halted  out  1  controller is in HALTED
- StackOverflow  out  1  sticky error flag
- StackUnderflow  out  1  sticky error flag
- StackDepth  out  $clog2(STACK_DEPTH)+1  occupied stack entries

Behaviour:
- Reset is asynchronous, active-high; clock is Clock.
- Reset state: state=RUN, flags=0, StackDepth=0, both error flags=0.
- While Reset is high, every output is forced to 0.
- Control outputs are combinational from the current inputs and registered state, giving zero-cycle latency; the PC acts on the next rising edge.
- All registered state (flags, stack, FSM, error flags) updates on the rising edge.
- Default outputs: LoadEnable=0, OffsetEnable=0, LoadValue=0, Offset=0. The PC then increments.
- Opcodes, evaluated only in RUN with InstrValid=1:
  - 0 NOP: defaults.
  - 1 JMP: LoadEnable=1, LoadValue=Target.
  - 2 BR: OffsetEnable=1, Offset=Immediate.
  - 3 BZ / 4 BNZ / 5 BN / 6 BC / 7 BV: as BR if the registered flag condition holds (Z=1 / Z=0 / N=1 / C=1 / V=1), otherwise defaults.
  - 8 CALL: push InstrPC+1 (wraps modulo 2^ADDR_WIDTH); LoadEnable=1, LoadValue=Target.
  - 9 RET: pop; LoadEnable=1, LoadValue=popped entry.
  - A HALT: enter HALTED.
  - B–F: treated as NOP.
- Taken transfer: JMP, BR, a Bcc whose condition holds, a successful CALL, or a successful RET. A not-taken Bcc is not a taken transfer.
- A taken transfer moves the FSM RUN→FLUSH.
- FLUSH:
  - Lasts exactly one cycle; Flush=1.
  - The slot's instruction is ignored (no decode, no stack change) and defaults are driven.
  - Returns to RUN on the next edge.
- HALTED:
  - OffsetEnable=1, Offset=0, so the PC holds.
  - Halted=1; all instructions are ignored.
  - Exited only by Reset.
- Flags register:
  - Loads FlagsIn on an edge where FlagsWrite=1, regardless of state.
  - A Bcc evaluates the registered value, so a FlagsWrite in the same cycle affects only later branches.
- Stack:
  - LIFO; StackDepth counts entries.
  - CALL with StackDepth=STACK_DEPTH: no push, no load, StackOverflow←1, go to HALTED; PC holds from the next cycle.
  - RET with StackDepth=0: no load, StackUnderflow←1, go to HALTED.
  - Error flags clear only on Reset.
- InstrValid=0 in RUN: defaults, no state change.
- Reset asserted mid-FLUSH or mid-HALTED: immediate return to the reset state.

Test Plan:
- Reset, then InstrValid=1, Opcode=1, Target=16'h0040 → same cycle LoadEnable=1, LoadValue=0x0040; next cycle Flush=1 with outputs at defaults; the cycle after, back to RUN.
- Opcode=2, Immediate=-9'sd4 → OffsetEnable=1, Offset=-4. BZ with Z=0 → defaults and no Flush. Then FlagsWrite=1 with FlagsIn=4'b0001 alongside BZ → not taken; BZ next RUN cycle → taken.
- CALL at InstrPC=0x0010, Target=0x0100 → StackDepth=1. After the FLUSH, RET → LoadValue=0x0011, StackDepth=0. CALL at InstrPC=0xFFFF → pushed value 0x0000.
- Eight nested CALLs → StackDepth=8. Ninth CALL → LoadEnable=0, StackOverflow=1; next cycle Halted=1, OffsetEnable=1, Offset=0.
- RET with an empty stack → StackUnderflow=1 then Halted=1. HALT opcode → Halted=1 held for 20 cycles despite valid JMPs presented.
- Assert Reset during FLUSH and during HALTED → all outputs 0 immediately; after release, state RUN and StackDepth=0.

Source files
------------

// File: rtl/branch_controller.sv
// Control-transfer stage feeding the program counter: decodes JMP/BR/Bcc/CALL/RET/HALT.
// Zero-cycle latency: PC control outputs are combinational from inputs and registered state.
// No backpressure: a taken transfer squashes the next slot, and HALTED freezes the PC until Reset.
module branch_controller #(
   parameter int STACK_DEPTH  = 8,
   parameter int ADDR_WIDTH   = 16,
   parameter int OFFSET_WIDTH = 9
) (
   input  logic                            Clock,
   input  logic                            Reset,
   input  logic                            InstrValid,
   input  logic [3:0]                      Opcode,
   input  logic [ADDR_WIDTH-1:0]           InstrPC,
   input  logic [ADDR_WIDTH-1:0]           Target,
   input  logic [OFFSET_WIDTH-1:0]         Immediate,
   input  logic [3:0]                      FlagsIn,
   input  logic                            FlagsWrite,
   output logic [ADDR_WIDTH-1:0]           LoadValue,
   output logic                            LoadEnable,
   output logic [OFFSET_WIDTH-1:0]         Offset,
   output logic                            OffsetEnable,
   output logic                            Flush,
   output logic                            Halted,
   output logic                            StackOverflow,
   output logic                            StackUnderflow,
   output logic [$clog2(STACK_DEPTH):0]    StackDepth
);

   localparam int PW = $clog2(STACK_DEPTH);
   localparam int DW = PW + 1;

   typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              flags;            // {V,C,N,Z}
   logic [ADDR_WIDTH-1:0]   stack_mem [STACK_DEPTH];
   logic [DW-1:0]           depth;
   logic                    ovf_q, unf_q;

   logic                    push, pop, set_ovf, set_unf, cond;
   logic                    le_c, oe_c;
   logic [ADDR_WIDTH-1:0]   lv_c;
   logic [OFFSET_WIDTH-1:0] off_c;
   logic [PW-1:0]           push_idx, top_idx;
   logic [ADDR_WIDTH-1:0]   top_entry;

   // Stack pointers: push writes at depth, pop reads the entry just below it.
   assign push_idx  = depth[PW-1:0];
   assign top_idx   = PW'(depth - 1'b1);
   assign top_entry = stack_mem[top_idx];

   // Decode the execute slot and pick the next controller state.
   always_comb begin
      state_nxt = state;
      le_c      = 1'b0;
      lv_c      = '0;
      oe_c      = 1'b0;
      off_c     = '0;
      push      = 1'b0;
      pop       = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      cond      = 1'b0;
      case (state)
         RUN: begin
            if (InstrValid) begin
               case (Opcode)
                  4'h1: begin
                     le_c      = 1'b1;
                     lv_c      = Target;
                     state_nxt = FLUSH;
                  end
                  4'h2: begin
                     oe_c      = 1'b1;
                     off_c     = Immediate;
                     state_nxt = FLUSH;
                  end
                  4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                     case (Opcode)
                        4'h3:    cond = flags[0];
                        4'h4:    cond = !flags[0];
                        4'h5:    cond = flags[1];
                        4'h6:    cond = flags[2];
                        default: cond = flags[3];
                     endcase
                     if (cond) begin
                        oe_c      = 1'b1;
                        off_c     = Immediate;
                        state_nxt = FLUSH;
                     end
                  end
                  4'h8: begin
                     if (depth == DW'(STACK_DEPTH)) begin
                        set_ovf   = 1'b1;
                        state_nxt = HALTED;
                     end else begin
                        push      = 1'b1;
                        le_c      = 1'b1;
                        lv_c      = Target;
                        state_nxt = FLUSH;
                     end
                  end
                  4'h9: begin
                     if (depth == '0) begin
                        set_unf   = 1'b1;
                        state_nxt = HALTED;
                     end else begin
                        pop       = 1'b1;
                        le_c      = 1'b1;
                        lv_c      = top_entry;
                        state_nxt = FLUSH;
                     end
                  end
                  4'hA:    state_nxt = HALTED;
                  default: ;
               endcase
            end
         end
         FLUSH:   state_nxt = RUN;
         // A zero offset with OffsetEnable keeps the PC parked.
         HALTED:  oe_c = 1'b1;
         default: state_nxt = RUN;
      endcase
   end

   // Outputs are forced low for as long as Reset is held.
   assign LoadEnable     = !Reset && le_c;
   assign LoadValue      = Reset ? '0 : lv_c;
   assign OffsetEnable   = !Reset && oe_c;
   assign Offset         = Reset ? '0 : off_c;
   assign Flush          = !Reset && (state == FLUSH);
   assign Halted         = !Reset && (state == HALTED);
   assign StackOverflow  = !Reset && (ovf_q || set_ovf);
   assign StackUnderflow = !Reset && (unf_q || set_unf);
   assign StackDepth     = Reset ? '0 : depth;

   // Controller state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Condition flags load whenever the ALU writes, independent of state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)           flags <= '0;
      else if (FlagsWrite) flags <= FlagsIn;
   end

   // Stack occupancy and sticky error flags.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         depth <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push)     depth <= depth + 1'b1;
         else if (pop) depth <= depth - 1'b1;
         if (set_ovf)  ovf_q <= 1'b1;
         if (set_unf)  unf_q <= 1'b1;
      end
   end

   // Return-address storage; the +1 wraps naturally at the top of the address space.
   always_ff @(posedge Clock) begin
      if (push) stack_mem[push_idx] <= InstrPC + 1'b1;
   end

endmodule
